// File: rtl/ysyx_25040129_icache_if.sv
// IFU-side read channel and AXI4 burst-read channel of the instruction cache.
// The cache is the slave on the IFU side and the master on the memory side.
interface ysyx_25040129_icache_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
  modport slave  (input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
endinterface

interface ysyx_25040129_icache_mem_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (output araddr, arlen, arsize, arburst, arvalid, rready,
                  input arready, rdata, rresp, rlast, rvalid);
  modport slave  (input araddr, arlen, arsize, arburst, arvalid, rready,
                  output arready, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/ysyx_25040129_icache.sv
// Direct-mapped, read-only instruction cache: 1-cycle hits, whole-line AXI4 INCR refill.
// LINE_WORDS must be at least 2 (the word counter needs one bit).
module ysyx_25040129_icache #(
  parameter int NLINES     = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic fence_i,
  ysyx_25040129_icache_if.slave      ifu,
  ysyx_25040129_icache_mem_if.master mem
);
  localparam int OFF_W = $clog2(LINE_WORDS * 4);
  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NLINES);
  localparam int TAG_W = 32 - OFF_W - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, REFILL, RESP} state_t;

  state_t            state, state_nxt;
  logic [31:2]       req_addr;
  logic [NLINES-1:0] valid;
  logic [TAG_W-1:0]  tags [NLINES];
  logic [31:0]       data [NLINES][LINE_WORDS];
  logic [WRD_W-1:0]  cnt;
  logic [31:0]       resp_data;
  logic [1:0]        resp_code, err_code, beat_code;
  logic              fence_seen;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WRD_W-1:0]  off;
  logic              hit, beat, last_k, proto_err;
  logic [31:0]       hit_word;

  assign idx      = req_addr[OFF_W +: IDX_W];
  assign tag      = req_addr[31 -: TAG_W];
  assign off      = req_addr[2 +: WRD_W];
  assign hit      = valid[idx] && (tags[idx] == tag);
  assign hit_word = data[idx][off];
  assign beat     = (state == REFILL) && mem.rvalid;
  assign last_k   = (cnt == WRD_W'(LINE_WORDS - 1));
  // rlast must coincide exactly with the last expected beat; early or missing rlast is an error
  assign proto_err = (mem.rlast != last_k);
  assign beat_code = (err_code != 2'b00)   ? err_code :
                     (mem.rresp != 2'b00)  ? mem.rresp :
                     proto_err             ? 2'b10 : 2'b00;

  assign mem.araddr  = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
  assign mem.arlen   = 8'(LINE_WORDS - 1);
  assign mem.arsize  = 3'b010;
  assign mem.arburst = 2'b01;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ifu.arready = 1'b0;
    ifu.rvalid  = 1'b0;
    ifu.rdata   = resp_data;
    ifu.rresp   = 2'b00;
    mem.arvalid = 1'b0;
    mem.rready  = 1'b0;
    case (state)
      IDLE: begin
        ifu.arready = 1'b1;
        if (ifu.arvalid) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          ifu.rvalid = 1'b1;
          ifu.rdata  = hit_word;
          state_nxt  = ifu.rready ? IDLE : RESP;
        end else begin
          state_nxt = MISS_AR;
        end
      end
      MISS_AR: begin
        mem.arvalid = 1'b1;
        if (mem.arready) state_nxt = REFILL;
      end
      REFILL: begin
        mem.rready = 1'b1;
        if (mem.rvalid && mem.rlast) state_nxt = RESP;
      end
      RESP: begin
        ifu.rvalid = 1'b1;
        ifu.rresp  = resp_code;
        if (ifu.rready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr   <= '0;
      valid      <= '0;
      cnt        <= '0;
      resp_data  <= '0;
      resp_code  <= 2'b00;
      err_code   <= 2'b00;
      fence_seen <= 1'b0;
    end else begin
      if (state == IDLE && ifu.arvalid) req_addr <= ifu.araddr[31:2];
      if (state == LOOKUP) begin
        if (hit) resp_data <= hit_word;
        resp_code  <= 2'b00;
        err_code   <= 2'b00;
        fence_seen <= fence_i;
      end
      if ((state == MISS_AR || state == REFILL) && fence_i) fence_seen <= 1'b1;
      if (beat) begin
        cnt      <= cnt + 1'b1;
        err_code <= beat_code;
        if (cnt == off) resp_data <= mem.rdata;
        if (mem.rlast) begin
          cnt       <= '0;
          resp_code <= beat_code;
        end
      end
      // the victim line is dropped before refill overwrites its words
      if (fence_i)
        valid <= '0;
      else if (state == LOOKUP && !hit)
        valid[idx] <= 1'b0;
      else if (beat && mem.rlast && beat_code == 2'b00 && !fence_seen)
        valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat) data[idx][cnt] <= mem.rdata;
    if (beat && mem.rlast) tags[idx] <= tag;
  end
endmodule

// File: doc/ysyx_25040129_icache.md
YSYX_25040129_ICACHE -- requirements
Module: ysyx_25040129_ICACHE

Interface
REQ-001 SHALL have parameter NLINES, default 16, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of 2); offset bits = log2(LINE_WORDS*4), index bits = log2(NLINES), tag = remaining upper bits.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports araddr/arvalid/arready  in/in/out  32/1/1  IFU-side read address channel.
REQ-006 SHALL have ports rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  IFU-side read data channel.
REQ-007 SHALL have port fence_i  input  1  invalidate all lines.
REQ-008 SHALL have ports mem_araddr/mem_arlen/mem_arsize/mem_arburst/mem_arvalid/mem_arready  out x5/in  32/8/3/2/1/1  AXI4 burst read address to memory.
REQ-009 SHALL have ports mem_rdata/mem_rresp/mem_rlast/mem_rvalid/mem_rready  in x4/out  32/2/1/1/1  AXI4 read data from memory.

Function
REQ-010 SHALL implement states IDLE, LOOKUP, MISS_AR, REFILL, RESP.
REQ-011 SHALL assert arready only in IDLE; on arvalid&&arready, latch araddr (low 2 bits ignored) and enter LOOKUP.
REQ-012 LOOKUP hit (valid[index] && tag match): drive rdata = line word, rresp=2'b00, rvalid=1 in the same LOOKUP cycle; rvalid&&rready -> IDLE, else -> RESP holding rdata/rresp stable until rready.
REQ-013 Hit latency SHALL be 1 cycle from address handshake to rvalid.
REQ-014 LOOKUP miss -> MISS_AR: mem_arvalid=1, mem_araddr = line-aligned address, mem_arlen=LINE_WORDS-1, mem_arsize=3'b010, mem_arburst=2'b01 (INCR), all stable until mem_arready; then -> REFILL.
REQ-015 REFILL: mem_rready=1; each beat writes word counter k (0..LINE_WORDS-1, wraps to 0 after last) into line; requested word captured for response when k equals request offset.
REQ-016 On beat with mem_rlast: write tag, set valid unless any beat had mem_rresp!=2'b00 or fence_i was seen during the miss; -> RESP with rvalid=1.
REQ-017 Error refill SHALL return rresp = first non-OKAY mem_rresp seen, leave line invalid.
REQ-018 fence_i SHALL clear every valid bit on the next edge in any state; in MISS_AR/REFILL the fill completes and data is returned but line stays invalid; a lookup in the same cycle as fence_i uses pre-clear valid bits.
REQ-019 mem_arvalid, mem_rready, rvalid SHALL be 0 outside MISS_AR, REFILL, and LOOKUP-hit/RESP respectively.
REQ-020 Only one outstanding IFU request; no new arready until response handshake completes.
REQ-021 mem_rlast arriving before LINE_WORDS beats, or extra beats, SHALL be treated as error (rresp=2'b10, line invalid).
REQ-022 Data array SHALL be plain registers; no write path from IFU side.

Reset
REQ-023 rst low SHALL immediately force state IDLE, all valid bits 0, word counter 0, arready=1 after deassertion, rvalid=0, mem_arvalid=0, mem_rready=0, rresp=0, rdata=0.
REQ-024 Reset mid-refill SHALL abandon the burst; memory side is also reset, no draining required.
REQ-025 Tag/data arrays need not be reset.

Verification
REQ-026 Cold read 0x8000_0004 with memory 0x8000_0000..0C = A0,A1,A2,A3 -> one burst araddr 0x8000_0000 arlen 3; rdata=A1 rresp 0 after 4th beat.
REQ-027 Immediate re-read 0x8000_000C -> rvalid cycle after handshake, rdata=A3, no mem_arvalid.
REQ-028 Read 0x8000_0100 (same index, different tag) then 0x8000_0000 -> two misses, both correct data.
REQ-029 Hit with rready held low 3 cycles -> rvalid/rdata stable for 4 cycles, arready low throughout.
REQ-030 fence_i pulse during refill beat 2 -> data returned, subsequent same-address read misses again.
REQ-031 Beat 1 mem_rresp=2'b10 -> IFU rresp=2'b10 after rlast; repeat read refills again; rst low mid-burst -> all outputs reset values same cycle.
